// File: rtl/serial_tc_deserializer.sv
// Serial two's-complement deserializer: receives an LSB-first frame and
// negates it on the fly (copy through the first 1, invert afterwards).
// The result is assembled into a parallel word with a one-cycle valid
// strobe and a flag for the unrepresentable most-negative result.
module serial_tc_deserializer #(
  parameter int WIDTH = 8
) (
  input  logic             t_clk,
  input  logic             r,
  input  logic             i,
  input  logic             i_valid,
  input  logic             i_start,
  output logic [WIDTH-1:0] y,
  output logic             y_valid,
  output logic             ovf,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               seen_one, seen_one_nxt;
  // Only WIDTH-1 bits need storing; the last converted bit joins them on
  // the completion edge to form the full word.
  logic [WIDTH-2:0]   sr, sr_nxt;
  logic [WIDTH-1:0]   y_nxt;
  logic               y_valid_nxt, ovf_nxt;

  logic               first;
  logic               accept;
  logic               done;
  logic               o;
  logic [WIDTH-1:0]   word;

  // Result 2^(WIDTH-1) has no positive counterpart in WIDTH bits.
  function automatic logic is_most_neg(input logic [WIDTH-1:0] w);
    return w == {1'b1, {(WIDTH-1){1'b0}}};
  endfunction

  assign busy = (state == RECV);

  // Next-state, datapath and output-strobe logic for each accepted bit.
  always_comb begin
    first        = i_valid && i_start;
    accept       = i_valid && (i_start || (state == RECV));
    // A start bit restarts the copy/invert rule regardless of history.
    o            = i ^ (seen_one && !first);
    word         = {o, sr};
    done         = accept && !first && (cnt == CNT_W'(WIDTH - 1));

    state_nxt    = state;
    cnt_nxt      = cnt;
    seen_one_nxt = seen_one;
    sr_nxt       = sr;
    y_nxt        = y;
    y_valid_nxt  = 1'b0;
    ovf_nxt      = 1'b0;

    if (accept) begin
      sr_nxt = word[WIDTH-1:1];
      if (done) begin
        state_nxt    = IDLE;
        cnt_nxt      = '0;
        seen_one_nxt = 1'b0;
        y_nxt        = word;
        y_valid_nxt  = 1'b1;
        ovf_nxt      = is_most_neg(word);
      end else begin
        // A start while receiving aborts the old frame silently.
        state_nxt    = RECV;
        cnt_nxt      = first ? CNT_W'(1) : cnt + CNT_W'(1);
        seen_one_nxt = (seen_one && !first) || i;
      end
    end
  end

  // State, shift register and output registers; reset drops any partial frame.
  always_ff @(posedge t_clk or posedge r) begin
    if (r) begin
      state    <= IDLE;
      cnt      <= '0;
      seen_one <= 1'b0;
      sr       <= '0;
      y        <= '0;
      y_valid  <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      seen_one <= seen_one_nxt;
      sr       <= sr_nxt;
      y        <= y_nxt;
      y_valid  <= y_valid_nxt;
      ovf      <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_serial_tc_deserializer.sv
// Testbench for serial_tc_deserializer: directed scenarios plus randomized
// frames checked against arithmetic negation of the raw frame value.
module tb_serial_tc_deserializer;

  localparam int W = 8;

  logic         t_clk = 1'b0;
  logic         r = 1'b0;
  logic         i = 1'b0;
  logic         i_valid = 1'b0;
  logic         i_start = 1'b0;
  logic [W-1:0] y;
  logic         y_valid;
  logic         ovf;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int cyc = 0;

  serial_tc_deserializer #(.WIDTH(W)) dut (
    .t_clk   (t_clk),
    .r       (r),
    .i       (i),
    .i_valid (i_valid),
    .i_start (i_start),
    .y       (y),
    .y_valid (y_valid),
    .ovf     (ovf),
    .busy    (busy)
  );

  always #5 t_clk = ~t_clk;

  always @(posedge t_clk) cyc = cyc + 1;

  // Count strobes and watch that ovf never appears without y_valid.
  always @(negedge t_clk) begin
    if (y_valid === 1'b1) pulses = pulses + 1;
    checks = checks + 1;
    if (ovf === 1'b1 && y_valid !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL ovf_without_valid ovf=%b y_valid=%b", ovf, y_valid);
    end
  end

  task automatic send_bit(input logic b, input logic v, input logic s);
    @(negedge t_clk);
    i       = b;
    i_valid = v;
    i_start = s;
  endtask

  task automatic tick();
    @(posedge t_clk);
    #1;
  endtask

  task automatic test_reset();
    r = 1'b1;
    repeat (2) @(posedge t_clk);
    @(negedge t_clk);
    r = 1'b0;
    i_valid = 1'b0;
    tick();
    checks++; if (y !== 8'h00) begin errors++; $display("FAIL reset_y got %h exp 00", y); end
    checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL reset_y_valid got %b exp 0", y_valid); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", ovf); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
  endtask

  task automatic test_single();
    logic [W-1:0] raw;
    raw = 8'h05;
    for (int k = 0; k < W; k++) begin
      send_bit(raw[k], 1'b1, k == 0);
      tick();
      if (k < W - 1) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy bit%0d got %b exp 1", k, busy); end
        checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid bit%0d got %b exp 0", k, y_valid); end
      end else begin
        checks++; if (y_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", y_valid); end
        checks++; if (y !== 8'hFB) begin errors++; $display("FAIL single_y got %h exp fb", y); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL single_ovf got %b exp 0", ovf); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end got %b exp 0", busy); end
      end
    end
    send_bit(1'b0, 1'b0, 1'b0);
    tick();
    checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL single_strobe_len got %b exp 0", y_valid); end
    checks++; if (y !== 8'hFB) begin errors++; $display("FAIL single_hold got %h exp fb", y); end
  endtask

  task automatic test_back_to_back();
    logic [2*W-1:0] raw;
    int p0, c1, c2;
    raw = 16'h0080;
    p0 = pulses;
    c1 = 0;
    c2 = 0;
    for (int k = 0; k < 2 * W; k++) begin
      send_bit(raw[k], 1'b1, (k % W) == 0);
      tick();
      if (k == W - 1) begin
        c1 = cyc;
        checks++; if (y_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid1 got %b exp 1", y_valid); end
        checks++; if (y !== 8'h80) begin errors++; $display("FAIL b2b_y1 got %h exp 80", y); end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL b2b_ovf1 got %b exp 1", ovf); end
      end else if (k == 2 * W - 1) begin
        c2 = cyc;
        checks++; if (y_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid2 got %b exp 1", y_valid); end
        checks++; if (y !== 8'h00) begin errors++; $display("FAIL b2b_y2 got %h exp 00", y); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL b2b_ovf2 got %b exp 0", ovf); end
      end
    end
    send_bit(1'b0, 1'b0, 1'b0);
    tick();
    checks++; if (c2 - c1 !== W) begin errors++; $display("FAIL b2b_spacing got %0d exp %0d", c2 - c1, W); end
    checks++; if (pulses - p0 !== 2) begin errors++; $display("FAIL b2b_pulses got %0d exp 2", pulses - p0); end
  endtask

  task automatic test_stall();
    logic [W-1:0] raw;
    int c0, p0;
    raw = 8'hFB;
    p0 = pulses;
    c0 = 0;
    for (int k = 0; k < W; k++) begin
      send_bit(raw[k], 1'b1, k == 0);
      tick();
      if (k == 0) c0 = cyc;
      if (k == 3) begin
        for (int s = 0; s < 3; s++) begin
          send_bit(1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));
          tick();
          checks++; if (y_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL stall_hold got v=%b busy=%b exp v=0 busy=1", y_valid, busy); end
        end
      end
    end
    checks++; if (y_valid !== 1'b1) begin errors++; $display("FAIL stall_valid got %b exp 1", y_valid); end
    checks++; if (y !== 8'h05) begin errors++; $display("FAIL stall_y got %h exp 05", y); end
    checks++; if (cyc - c0 !== W - 1 + 3) begin errors++; $display("FAIL stall_latency got %0d exp %0d", cyc - c0, W + 2); end
    send_bit(1'b0, 1'b0, 1'b0);
    tick();
    checks++; if (pulses - p0 !== 1) begin errors++; $display("FAIL stall_pulses got %0d exp 1", pulses - p0); end
  endtask

  task automatic test_abort_reset();
    logic [W-1:0] raw_a, raw_b, raw_c;
    int p0;
    raw_a = 8'h07;
    raw_b = 8'h01;
    raw_c = 8'h5A;
    p0 = pulses;
    for (int k = 0; k < 3; k++) begin
      send_bit(raw_a[k], 1'b1, k == 0);
      tick();
    end
    for (int k = 0; k < W; k++) begin
      send_bit(raw_b[k], 1'b1, k == 0);
      tick();
    end
    checks++; if (y_valid !== 1'b1) begin errors++; $display("FAIL abort_valid got %b exp 1", y_valid); end
    checks++; if (y !== 8'hFF) begin errors++; $display("FAIL abort_y got %h exp ff", y); end
    send_bit(1'b0, 1'b0, 1'b0);
    tick();
    checks++; if (pulses - p0 !== 1) begin errors++; $display("FAIL abort_pulses got %0d exp 1", pulses - p0); end
    p0 = pulses;
    for (int k = 0; k < 4; k++) begin
      send_bit(raw_c[k], 1'b1, k == 0);
      tick();
    end
    @(negedge t_clk);
    i_valid = 1'b0;
    #2;
    r = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    checks++; if (y !== 8'h00) begin errors++; $display("FAIL rst_y got %h exp 00", y); end
    checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", y_valid); end
    repeat (2) @(posedge t_clk);
    @(negedge t_clk);
    r = 1'b0;
    tick();
    checks++; if (pulses - p0 !== 0) begin errors++; $display("FAIL rst_pulses got %0d exp 0", pulses - p0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy_after got %b exp 0", busy); end
  endtask

  task automatic test_random();
    logic [W-1:0] raw, exp_y, prev_y;
    logic         exp_ovf;
    int p0, nframes;
    prev_y = 8'h00;
    p0 = pulses;
    nframes = 30;
    for (int f = 0; f < nframes; f++) begin
      raw = W'($urandom);
      if (f == 0) raw = 8'h80;
      if (f == 1) raw = 8'h00;
      if (f == 2) raw = 8'h7F;
      // Reference: the frame value negated modulo 2^W.
      exp_y   = -raw;
      exp_ovf = (raw == 8'h80);
      // Idle junk: bits without start in IDLE must be ignored.
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        send_bit(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        tick();
      end
      for (int k = 0; k < W; k++) begin
        if (k > 0) begin
          for (int s = 0; s < int'($urandom_range(0, 2)); s++) begin
            send_bit(1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));
            tick();
          end
        end
        send_bit(raw[k], 1'b1, k == 0);
        tick();
        if (k < W - 1) begin
          checks++; if (y_valid !== 1'b0 || y !== prev_y) begin errors++; $display("FAIL rnd_mid f%0d k%0d got v=%b y=%h exp v=0 y=%h", f, k, y_valid, y, prev_y); end
        end else begin
          checks++; if (y_valid !== 1'b1) begin errors++; $display("FAIL rnd_valid f%0d got %b exp 1", f, y_valid); end
          checks++; if (y !== exp_y) begin errors++; $display("FAIL rnd_y f%0d raw=%h got %h exp %h", f, raw, y, exp_y); end
          checks++; if (ovf !== exp_ovf) begin errors++; $display("FAIL rnd_ovf f%0d raw=%h got %b exp %b", f, raw, ovf, exp_ovf); end
        end
      end
      prev_y = exp_y;
    end
    send_bit(1'b0, 1'b0, 1'b0);
    tick();
    checks++; if (pulses - p0 !== nframes) begin errors++; $display("FAIL rnd_pulses got %0d exp %0d", pulses - p0, nframes); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_abort_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
